// File: rtl/branch_pkg.sv
// Shared types, widths and counter helpers for the branch predictor.
// Default geometry: 9-bit PC, 16-entry direct-mapped BTB.
package branch_pkg;

  localparam int BP_PC_W    = 9;
  localparam int BP_ENTRIES = 16;
  localparam int BP_STAT_W  = 16;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_PC_W - 2 - BP_IDX_W;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_PC_W-1:0]  target;
    ctr_t                ctr;
  } bp_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table.sv
// BTB storage: async-reset entries, two combinational read ports
// (fetch lookup, EX read-modify-write) and one write port.
module btb_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output bp_entry_t        rd_a_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output bp_entry_t        rd_b_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  bp_entry_t        wr_entry_i
);

  localparam bp_entry_t RST_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    WNT
  };

  bp_entry_t tbl_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= RST_ENTRY;
      end
    end else if (we_i) begin
      tbl_q[wr_idx_i] <= wr_entry_i;
    end
  end

  // Reads see pre-update contents; no write bypass.
  assign rd_a_o = tbl_q[rd_a_idx_i];
  assign rd_b_o = tbl_q[rd_b_idx_i];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch unit: BTB lookup at fetch, resolution and redirect at EX,
// table training and saturating statistics.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W    = BP_PC_W,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int STAT_W  = BP_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [31:0]       ex_imm,
  input  logic              ex_branch,
  input  logic              ex_jal,
  input  logic              ex_jalr,
  input  logic [31:0]       ex_alu_result,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  output logic [31:0]       pc_four,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  bp_entry_t        if_ent;
  bp_entry_t        ex_ent;
  bp_entry_t        wr_ent;
  logic             we;
  logic             if_hit;
  logic             ex_hit;
  logic [31:0]      ex_pc_ext;
  logic [31:0]      act_target;
  logic             act_taken;
  logic             mispred;
  logic             unused_pc_lsb;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  assign unused_pc_lsb = ^if_pc[1:0];

  btb_table #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_a_idx_i (if_idx),
    .rd_a_o     (if_ent),
    .rd_b_idx_i (ex_idx),
    .rd_b_o     (ex_ent),
    .we_i       (we),
    .wr_idx_i   (ex_idx),
    .wr_entry_i (wr_ent)
  );

  assign if_hit      = if_ent.valid && (if_ent.tag == if_tag);
  assign pred_taken  = if_hit && if_ent.ctr[1];
  assign pred_target = pred_taken
                     ? {{(32-PC_W){1'b0}}, if_ent.target}
                     : 32'd0;

  assign ex_pc_ext  = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_four    = ex_pc_ext + 32'd4;
  assign act_target = ex_jalr ? ex_alu_result : ex_pc_ext + ex_imm;
  assign act_taken  = ex_valid
                    && ((ex_branch && ex_alu_result[0])
                        || ex_jal || ex_jalr);

  assign mispred = ex_valid
                 && ((act_taken != ex_pred_taken)
                     || (act_taken
                         && (ex_pred_target != act_target)));

  assign redirect    = mispred;
  assign redirect_pc = !mispred ? 32'd0
                     : act_taken ? act_target
                     : pc_four;

  assign ex_hit = ex_ent.valid && (ex_ent.tag == ex_tag);

  always_comb begin
    we     = 1'b0;
    wr_ent = ex_ent;
    // jalr targets are data dependent, so they are never cached.
    if (ex_valid && !ex_jalr) begin
      if (ex_jal) begin
        we     = 1'b1;
        wr_ent = '{
          valid:  1'b1,
          tag:    ex_tag,
          target: act_target[PC_W-1:0],
          ctr:    ST
        };
      end else if (ex_branch) begin
        if (ex_hit) begin
          we         = 1'b1;
          wr_ent.ctr = act_taken ? sat_inc(ex_ent.ctr)
                                 : sat_dec(ex_ent.ctr);
          if (act_taken) begin
            wr_ent.target = act_target[PC_W-1:0];
          end
        end else if (act_taken) begin
          we     = 1'b1;
          wr_ent = '{
            valid:  1'b1,
            tag:    ex_tag,
            target: act_target[PC_W-1:0],
            ctr:    WT
          };
        end
      end
    end
  end

  logic [STAT_W-1:0] br_count_q;
  logic [STAT_W-1:0] br_count_d;
  logic [STAT_W-1:0] mis_count_q;
  logic [STAT_W-1:0] mis_count_d;
  logic              br_inc;

  assign br_inc = ex_valid && (ex_branch || ex_jal || ex_jalr);

  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (br_inc && !(&br_count_q)) begin
      br_count_d = br_count_q + STAT_W'(1);
    end
    if (mispred && !(&mis_count_q)) begin
      mis_count_d = mis_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mis_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed vector table, mid-cycle reset
// sequence, then random traffic against a behavioural model.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [8:0]  if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic [31:0] ex_imm;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic [31:0] ex_alu_result;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc_four;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  branch_predict_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_branch      (ex_branch),
    .ex_jal         (ex_jal),
    .ex_jalr        (ex_jalr),
    .ex_alu_result  (ex_alu_result),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_four        (pc_four),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ty: 0 branch, 1 jal, 2 jalr, 3 no control-flow flag
  typedef struct {
    logic [8:0]  ifpc;
    logic        ev;
    logic [8:0]  expc;
    logic [31:0] imm;
    int          ty;
    logic [31:0] alu;
    logic        ept;
    logic [31:0] etgt;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_red;
    logic [31:0] e_rpc;
    int          e_br;
    int          e_mis;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [8:0] ifpc, input logic ev, input logic [8:0] expc,
    input logic [31:0] imm, input int ty, input logic [31:0] alu,
    input logic ept, input logic [31:0] etgt, input logic e_pt,
    input logic [31:0] e_ptgt, input logic e_red,
    input logic [31:0] e_rpc, input int e_br, input int e_mis);
    vec_t v;
    v.ifpc = ifpc; v.ev = ev; v.expc = expc; v.imm = imm;
    v.ty = ty; v.alu = alu; v.ept = ept; v.etgt = etgt;
    v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_red = e_red;
    v.e_rpc = e_rpc; v.e_br = e_br; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic drive(input logic [8:0] ifpc, input logic ev,
                       input logic [8:0] expc, input logic [31:0] imm,
                       input int ty, input logic [31:0] alu,
                       input logic ept, input logic [31:0] etgt);
    if_pc          = ifpc;
    ex_valid       = ev;
    ex_pc          = expc;
    ex_imm         = imm;
    ex_branch      = (ty == 0);
    ex_jal         = (ty == 1);
    ex_jalr        = (ty == 2);
    ex_alu_result  = alu;
    ex_pred_taken  = ept;
    ex_pred_target = etgt;
  endtask

  task automatic idle(input logic [8:0] ifpc);
    drive(ifpc, 1'b0, 9'h0, 32'h0, 3, 32'h0, 1'b0, 32'h0);
  endtask

  // Behavioural model: plain arrays indexed by pc/4 mod 16.
  int m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_br;
  int m_mis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  function automatic void mlook(input int pc, output logic pt,
                                output logic [31:0] tg);
    int i;
    i = (pc / 4) % 16;
    pt = (m_valid[i] != 0) && (m_tag[i] == pc / 64)
         && (m_ctr[i] >= 2);
    tg = pt ? 32'(m_tgt[i]) : 32'd0;
  endfunction

  initial begin
    logic        e_pt, e_red, taken, ept;
    logic [31:0] e_tg, e_rpc, tgt, etgt, imm, alu;
    int          pc, ipc, ty, ev, i;

    rst_n = 1'b0;
    idle(9'h040);
    repeat (2) @(negedge clk);
    #1;
    chk("reset pred_taken", 32'(pred_taken), 32'd0);
    chk("reset pred_target", pred_target, 32'd0);
    chk("reset redirect", 32'(redirect), 32'd0);
    chk("reset br_count", 32'(br_count), 32'd0);
    chk("reset mispred_count", 32'(mispred_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vq.push_back(mk(9'h040,0,9'h000,0,3,0,0,0, 0,0,0,0, 0,0));
    vq.push_back(mk(9'h040,1,9'h040,32'h20,0,1,0,0, 0,0,1,32'h60, 0,0));
    vq.push_back(mk(9'h040,0,9'h000,0,3,0,0,0, 1,32'h60,0,0, 1,1));
    vq.push_back(mk(9'h040,1,9'h040,32'h20,0,0,1,32'h60,
                    1,32'h60,1,32'h44, 1,1));
    vq.push_back(mk(9'h040,0,9'h000,0,3,0,0,0, 0,0,0,0, 2,2));
    vq.push_back(mk(9'h040,1,9'h040,32'h20,0,1,0,0, 0,0,1,32'h60, 2,2));
    for (int k = 0; k < 4; k++) begin
      vq.push_back(mk(9'h040,1,9'h040,32'h20,0,1,1,32'h60,
                      1,32'h60,0,0, 3+k,3));
    end
    vq.push_back(mk(9'h040,0,9'h000,0,3,0,0,0, 1,32'h60,0,0, 7,3));
    vq.push_back(mk(9'h040,1,9'h040,32'h20,0,0,1,32'h60,
                    1,32'h60,1,32'h44, 7,3));
    vq.push_back(mk(9'h040,0,9'h000,0,3,0,0,0, 1,32'h60,0,0, 8,4));
    vq.push_back(mk(9'h080,1,9'h080,0,2,32'h1F0,0,0,
                    0,0,1,32'h1F0, 8,4));
    vq.push_back(mk(9'h080,0,9'h000,0,3,0,0,0, 0,0,0,0, 9,5));
    vq.push_back(mk(9'h000,1,9'h000,32'h100,1,0,0,0,
                    0,0,1,32'h100, 9,5));
    vq.push_back(mk(9'h0C0,0,9'h000,0,3,0,0,0, 0,0,0,0, 10,6));
    vq.push_back(mk(9'h000,0,9'h000,0,3,0,0,0, 1,32'h100,0,0, 10,6));
    vq.push_back(mk(9'h000,1,9'h000,32'h100,1,0,1,32'h100,
                    1,32'h100,0,0, 10,6));

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].ifpc, vq[k].ev, vq[k].expc, vq[k].imm, vq[k].ty,
            vq[k].alu, vq[k].ept, vq[k].etgt);
      #1;
      chk($sformatf("v%0d pred_taken", k), 32'(pred_taken),
          32'(vq[k].e_pt));
      chk($sformatf("v%0d pred_target", k), pred_target,
          vq[k].e_ptgt);
      chk($sformatf("v%0d redirect", k), 32'(redirect),
          32'(vq[k].e_red));
      chk($sformatf("v%0d redirect_pc", k), redirect_pc,
          vq[k].e_rpc);
      chk($sformatf("v%0d br_count", k), 32'(br_count),
          32'(vq[k].e_br));
      chk($sformatf("v%0d mispred_count", k), 32'(mispred_count),
          32'(vq[k].e_mis));
    end

    // Reset asserted between edges while a taken branch resolves.
    @(negedge clk);
    drive(9'h000, 1'b1, 9'h100, 32'h10, 0, 32'h1, 1'b0, 32'h0);
    #1;
    chk("pre-rst pred_taken", 32'(pred_taken), 32'd1);
    chk("pre-rst br_count", 32'(br_count), 32'd11);
    #1 rst_n = 1'b0;
    #1;
    chk("rst pred_taken", 32'(pred_taken), 32'd0);
    chk("rst pred_target", pred_target, 32'd0);
    chk("rst br_count", 32'(br_count), 32'd0);
    chk("rst mispred_count", 32'(mispred_count), 32'd0);
    chk("rst redirect comb", 32'(redirect), 32'd1);
    chk("rst redirect_pc comb", redirect_pc, 32'h110);
    @(negedge clk);
    rst_n = 1'b1;
    idle(9'h100);
    #1;
    chk("post-rst lost update", 32'(pred_taken), 32'd0);
    chk("post-rst br_count", 32'(br_count), 32'd0);
    chk("post-rst mispred_count", 32'(mispred_count), 32'd0);
    chk("post-rst redirect idle", 32'(redirect), 32'd0);

    model_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      ipc = int'($urandom_range(0, 3)) * 64
          + int'($urandom_range(0, 3)) * 4
          + int'($urandom_range(0, 3));
      pc  = int'($urandom_range(0, 7)) * 64
          + int'($urandom_range(0, 3)) * 4;
      ev  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ty  = int'($urandom_range(0, 3));
      imm = $urandom & 32'h3FC;
      if ($urandom_range(0, 3) == 0) imm = -imm;
      alu = $urandom;
      mlook(pc, ept, etgt);
      if ($urandom_range(0, 4) == 0) ept = ~ept;
      if ($urandom_range(0, 4) == 0) etgt = $urandom & 32'h1FC;
      drive(9'(ipc), ev[0], 9'(pc), imm, ty, alu, ept, etgt);
      #1;
      taken = (ev != 0) && ((ty == 0 && alu[0]) || ty == 1 || ty == 2);
      tgt   = (ty == 2) ? alu : 32'(pc) + imm;
      e_red = (ev != 0)
            && ((taken != ept) || (taken && etgt != tgt));
      e_rpc = !e_red ? 32'd0 : taken ? tgt : 32'(pc + 4);
      mlook(ipc, e_pt, e_tg);
      chk($sformatf("r%0d pred_taken", n), 32'(pred_taken),
          32'(e_pt));
      chk($sformatf("r%0d pred_target", n), pred_target, e_tg);
      chk($sformatf("r%0d redirect", n), 32'(redirect), 32'(e_red));
      chk($sformatf("r%0d redirect_pc", n), redirect_pc, e_rpc);
      chk($sformatf("r%0d pc_four", n), pc_four, 32'(pc + 4));
      chk($sformatf("r%0d br_count", n), 32'(br_count), 32'(m_br));
      chk($sformatf("r%0d mispred_count", n), 32'(mispred_count),
          32'(m_mis));
      i = (pc / 4) % 16;
      if (ev != 0 && ty == 1) begin
        m_valid[i] = 1; m_tag[i] = pc / 64;
        m_tgt[i] = int'(tgt % 512); m_ctr[i] = 3;
      end else if (ev != 0 && ty == 0) begin
        if (m_valid[i] != 0 && m_tag[i] == pc / 64) begin
          if (taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = int'(tgt % 512);
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (taken) begin
          m_valid[i] = 1; m_tag[i] = pc / 64;
          m_tgt[i] = int'(tgt % 512); m_ctr[i] = 2;
        end
      end
      if (ev != 0 && ty != 3 && m_br < 65535) m_br++;
      if (e_red && m_mis < 65535) m_mis++;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised branch unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- IF side: combinational lookup of the fetch PC produces a predicted direction and target.
- EX side: resolves branch/jal/jalr exactly as the single-cycle branch logic does (taken = branch && AluResult[0], or any jump), detects mispredictions, raises a redirect, and updates the table on the clock edge.
- Keeps saturating statistics counters for resolved branches and mispredictions.

Parameters:
- PC_W, 9, PC width in bits; PCs are word aligned, so bits [1:0] are ignored.
- ENTRIES, 16, number of BTB entries; power of 2, 2 <= ENTRIES < 2^(PC_W-2).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  fetch PC to look up.
- pred_taken  out  1  prediction for if_pc: 1 = taken.
- pred_target  out  32  predicted target, zero-extended; 0 when pred_taken = 0.
- ex_valid  in  1  a control-flow instruction is resolving in EX this cycle.
- ex_pc  in  PC_W  PC of the resolving instruction.
- ex_imm  in  32  immediate of the resolving instruction.
- ex_branch  in  1  conditional branch.
- ex_jal  in  1  jal.
- ex_jalr  in  1  jalr.
- ex_alu_result  in  32  bit 0 = branch condition; full value = jalr target.
- ex_pred_taken  in  1  prediction that travelled down the pipe with the instruction.
- ex_pred_target  in  32  predicted target that travelled with the instruction.
- pc_four  out  32  ex_pc + 4, zero-extended.
- redirect  out  1  misprediction: flush IF/ID and load redirect_pc.
- redirect_pc  out  32  corrected fetch PC.
- br_count  out  STAT_W  number of resolved instructions.
- mispred_count  out  STAT_W  number of mispredictions.

Behaviour:
- Geometry: IDX_W = log2(ENTRIES), TAG_W = PC_W-2-IDX_W. Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2].
- Entry fields: valid, tag (TAG_W bits), target (PC_W bits), ctr (2 bits). Counter encoding: 0 = strongly not-taken, 1 = weakly not-taken, 2 = weakly taken, 3 = strongly taken.
- Lookup (combinational, zero latency): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = pred_taken ? {zero, target} : 0.
- Resolution (combinational):
  - act_taken = ex_valid && ((ex_branch && ex_alu_result[0]) || ex_jal || ex_jalr).
  - act_target = ex_jalr ? ex_alu_result : {zero, ex_pc} + ex_imm, computed modulo 2^32.
- Misprediction: mispred = ex_valid && ((act_taken != ex_pred_taken) || (act_taken && ex_pred_target != act_target)).
- Outputs driven by mispred:
  - redirect = mispred.
  - redirect_pc = act_taken ? act_target : pc_four when mispred; otherwise 0.
- Table update (posedge clk, only when ex_valid and (ex_branch or ex_jal)):
  - Branch hit: ctr saturating +1 if taken, -1 if not taken. target <= act_target[PC_W-1:0] if taken.
  - Branch miss, taken: allocate entry (valid=1, tag, target) with ctr = 2, overwriting whatever is at that index.
  - Branch miss, not taken: no change.
  - jal: allocate or overwrite with ctr = 3.
  - jalr: never allocated and never updates the table. It still drives redirect and the statistics.
- Same-cycle read/write to the same index: the lookup returns the pre-update contents. There is no bypass.
- Both ex_branch and ex_jal asserted together is illegal stimulus. Priority is jalr > jal > branch, for targets only.
- Statistics:
  - br_count +1 on every ex_valid with any of branch, jal or jalr.
  - mispred_count +1 on every mispred.
  - Both saturate at all-ones.
- Reset (asynchronous, any time including mid-update):
  - All valid = 0, all ctr = 1, all targets = 0, both statistics counters = 0.
  - Hence pred_taken = 0 and pred_target = 0 immediately.
  - redirect follows its inputs and is not registered. When ex_valid = 0, redirect = 0.

Decomposition:
- Package branch_pkg holds:
  - Counter constants SNT, WNT, WT, ST.
  - bp_entry_t struct (valid, tag, target, ctr), parametrised through package localparams.
  - Functions sat_inc and sat_dec.
- One sub-module, btb_table: storage plus async-reset registers, combinational read port, and single write port.
- Top level keeps the resolution, misprediction, and statistics logic.

Test Plan:
All scenarios use the defaults: PC_W = 9, ENTRIES = 16, index = pc[5:2], tag = pc[8:6].
1. Reset, then if_pc = 0x040 -> pred_taken = 0. Resolve beq with ex_pc = 0x040, imm = 0x20, alu[0] = 1, ex_pred_taken = 0 -> redirect = 1, redirect_pc = 0x060. Next cycle if_pc = 0x040 -> pred_taken = 1, pred_target = 0x060.
2. Same branch resolves not-taken with ex_pred_taken = 1, ex_pred_target = 0x060 -> redirect = 1, redirect_pc = 0x044. ctr goes 2 -> 1, so lookup of 0x040 then gives pred_taken = 0.
3. Four taken resolutions of the same branch, then one more -> ctr saturates at 3 and stays 3. br_count increments by 5. mispred_count increments only on the cycles where the prediction was wrong.
4. jalr with ex_pc = 0x080, alu = 0x1F0, ex_pred_taken = 0 -> redirect = 1, redirect_pc = 0x1F0. Lookup of 0x080 still gives pred_taken = 0 (no allocation).
5. Aliasing: jal at 0x000 with imm 0x100 is allocated. Lookup of 0x0C0 (same index 0, different tag) -> pred_taken = 0. Lookup of 0x000 -> pred_target = 0x100. Correct prediction (ex_pred_taken = 1, ex_pred_target = 0x100) -> redirect = 0.
6. Assert rst_n low in the same cycle as a taken-branch update, between clock edges -> the table clears immediately, the update is lost, and both statistics counters read 0.
